// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready in/out handshakes, tag passthrough
// and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal
);
  localparam int SH = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [SH:0]      cnt_q, cnt_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic             n_q, n_d, z_q, z_d;
  logic             c_q, c_d, v_q, v_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ill_q, ill_d;
  logic             ov_q, ov_d;

  logic             accept, is_mul, mul_done;
  logic [SH-1:0]    shamt;
  logic [WIDTH:0]   sum, diff, sll_w, srl_w, sra_w;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic             add_v, sub_v, slt;

  assign in_ready = !rst && (state_q == IDLE)
                 && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ALUop == 4'b1011);
  assign mul_done = (state_q == MUL_RUN)
                 && (cnt_q == (SH+1)'(1));

  assign shamt = B[SH-1:0];
  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} - {1'b0, B};
  // Extra bit on each shift catches the last bit shifted out
  assign sll_w = {1'b0, A} << shamt;
  assign srl_w = {A, 1'b0} >> shamt;
  assign sra_w = $unsigned($signed({A, 1'b0}) >>> shamt);

  assign add_v = (A[WIDTH-1] == B[WIDTH-1])
              && (sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_v = (A[WIDTH-1] != B[WIDTH-1])
              && (diff[WIDTH-1] != A[WIDTH-1]);
  assign slt   = (A[WIDTH-1] != B[WIDTH-1])
              ? A[WIDTH-1] : diff[WIDTH-1];

  assign partial = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALUop)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = A ^ B;
      4'b0011: alu_res = ~(A | B);
      4'b0100: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      4'b0101: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = !diff[WIDTH];
        alu_v   = sub_v;
      end
      4'b0110: begin
        alu_res = {{(WIDTH-1){1'b0}}, slt};
        alu_c   = !diff[WIDTH];
        alu_v   = sub_v;
      end
      4'b0111: begin
        alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
        alu_c   = !diff[WIDTH];
        alu_v   = sub_v;
      end
      4'b1000: begin
        alu_res = sll_w[WIDTH-1:0];
        alu_c   = sll_w[WIDTH];
      end
      4'b1001: begin
        alu_res = srl_w[WIDTH:1];
        alu_c   = srl_w[0];
      end
      4'b1010: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      4'b1011: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mtag_q   <= '0;
      res_q    <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      tag_q    <= '0;
      ill_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mtag_q   <= mtag_d;
      res_q    <= res_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      tag_q    <= tag_d;
      ill_q    <= ill_d;
      ov_q     <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL_RUN;
      MUL_RUN: if (mul_done)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mtag_d   = mtag_q;
    res_d    = res_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    tag_d    = tag_q;
    ill_d    = ill_q;
    ov_d     = ov_q && !out_ready;
    if (state_q == MUL_RUN) begin
      prod_d   = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - (SH+1)'(1);
    end
    if (accept && is_mul) begin
      mcand_d  = A;
      mplier_d = B;
      prod_d   = '0;
      cnt_d    = (SH+1)'(WIDTH);
      mtag_d   = in_tag;
    end else if (accept) begin
      res_d = alu_res;
      n_d   = alu_res[WIDTH-1];
      z_d   = (alu_res == '0);
      c_d   = alu_c;
      v_d   = alu_v;
      tag_d = in_tag;
      ill_d = alu_ill;
      ov_d  = 1'b1;
    end
    if (mul_done) begin
      res_d = partial;
      n_d   = partial[WIDTH-1];
      z_d   = (partial == '0);
      c_d   = 1'b0;
      v_d   = 1'b0;
      tag_d = mtag_q;
      ill_d = 1'b0;
      ov_d  = 1'b1;
    end
  end

  assign out_valid = ov_q;
  assign Result    = res_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;
  assign out_tag   = tag_q;
  assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors, monitor pops
// expected results in order whenever an output is consumed.
module tb_alu_pipe;
  localparam int W = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic          n, z, c, v;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0, B = '0;
  logic [3:0]    ALUop = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  Result;
  logic          N, Z, C, V, illegal;
  logic [TW-1:0] out_tag;

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUop(ALUop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .N(N), .Z(Z), .C(C), .V(V),
    .out_tag(out_tag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [W-1:0] r,
      input logic c, input logic v, input logic [TW-1:0] t,
      input logic ill);
    exp_t e;
    e.res = r;
    e.n   = r[W-1];
    e.z   = (r == '0);
    e.c   = c;
    e.v   = v;
    e.tag = t;
    e.ill = ill;
    return e;
  endfunction

  // Drive one op, wait (bounded) for acceptance, queue its expectation
  task automatic issue(input logic [3:0] op,
      input logic [W-1:0] a, input logic [W-1:0] b,
      input logic [TW-1:0] t, input exp_t e);
    int n;
    ALUop = op; A = a; B = b; in_tag = t;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        a = '{res: Result, n: N, z: Z, c: C, v: V,
              tag: out_tag, ill: illegal};
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(a.res), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          total++;
          if (a === e) passed++;
          else $display("FAIL result: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #3;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_flags", 64'({N, Z, C, V, illegal}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("ready_after_rst", 64'(in_ready), 64'd1);

    issue(4'b0100, 32'h7FFFFFFF, 32'd1, 4'h1,
          mk(32'h80000000, 1'b0, 1'b1, 4'h1, 1'b0));
    issue(4'b0100, 32'hFFFFFFFF, 32'd1, 4'h2,
          mk(32'h0, 1'b1, 1'b0, 4'h2, 1'b0));
    issue(4'b0101, 32'd5, 32'd5, 4'h3,
          mk(32'h0, 1'b1, 1'b0, 4'h3, 1'b0));
    issue(4'b0101, 32'd3, 32'd5, 4'h4,
          mk(32'hFFFFFFFE, 1'b0, 1'b0, 4'h4, 1'b0));
    issue(4'b0110, 32'hFFFFFFFF, 32'd1, 4'h5,
          mk(32'd1, 1'b1, 1'b0, 4'h5, 1'b0));
    issue(4'b0111, 32'hFFFFFFFF, 32'd1, 4'h6,
          mk(32'd0, 1'b1, 1'b0, 4'h6, 1'b0));
    issue(4'b1000, 32'h80000001, 32'd1, 4'h7,
          mk(32'h2, 1'b1, 1'b0, 4'h7, 1'b0));
    issue(4'b1010, 32'h80000000, 32'd4, 4'h8,
          mk(32'hF8000000, 1'b0, 1'b0, 4'h8, 1'b0));
    issue(4'b1001, 32'h10, 32'd0, 4'h9,
          mk(32'h10, 1'b0, 1'b0, 4'h9, 1'b0));
    issue(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 4'hB,
          mk(32'hF000F000, 1'b0, 1'b0, 4'hB, 1'b0));
    issue(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 4'hC,
          mk(32'hFFF0FFF0, 1'b0, 1'b0, 4'hC, 1'b0));
    issue(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 4'hD,
          mk(32'h0FF00FF0, 1'b0, 1'b0, 4'hD, 1'b0));
    issue(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 4'hE,
          mk(32'h000F000F, 1'b0, 1'b0, 4'hE, 1'b0));

    // Multiply latency: busy for WIDTH cycles, result on WIDTH-th edge
    issue(4'b1011, 32'h0000FFFF, 32'h00010001, 4'hA,
          mk(32'hFFFFFFFF, 1'b0, 1'b0, 4'hA, 1'b0));
    begin
      int busy_bad, val_bad;
      busy_bad = 0;
      val_bad = 0;
      for (int i = 0; i < W; i++) begin
        @(negedge clk);
        if (in_ready) busy_bad++;
        if (out_valid) val_bad++;
      end
      chk("mul_busy_ready", 64'(busy_bad), 64'd0);
      chk("mul_early_valid", 64'(val_bad), 64'd0);
      @(negedge clk);
      chk("mul_valid_at_w", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;

    // Backpressure during a stream of four ADDs
    fork
      begin
        issue(4'b0100, 32'd1, 32'd2, 4'h1,
              mk(32'd3, 1'b0, 1'b0, 4'h1, 1'b0));
        issue(4'b0100, 32'h10, 32'h20, 4'h2,
              mk(32'h30, 1'b0, 1'b0, 4'h2, 1'b0));
        issue(4'b0100, 32'h100, 32'h100, 4'h3,
              mk(32'h200, 1'b0, 1'b0, 4'h3, 1'b0));
        issue(4'b0100, 32'hFFFFFFFE, 32'd1, 4'h4,
              mk(32'hFFFFFFFF, 1'b0, 1'b0, 4'h4, 1'b0));
      end
      begin
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_ready", 64'(in_ready), 64'd0);
          chk("stall_hold", 64'({out_valid, out_tag, Result}),
              64'({1'b1, 4'h1, 32'd3}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("stream_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a multiply aborts it
    issue(4'b1011, 32'd7, 32'd9, 4'h6,
          mk(32'd63, 1'b0, 1'b0, 4'h6, 1'b0));
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_outs", 64'({out_valid, N, Z, C, V, illegal, out_tag}),
        64'd0);
    chk("abort_result", 64'(Result), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_output", 64'(seen), 64'd0);
    end
    chk("abort_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    issue(4'b1111, 32'h1234, 32'h5678, 4'h5,
          mk(32'h0, 1'b0, 1'b0, 4'h5, 1'b1));
    repeat (3) @(posedge clk);
    #1 chk("final_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
